// File: rtl/obi_uart_baudgen_if.sv
// rtl/obi_uart_baudgen_if.sv - divisor programming inputs and strobe outputs of the baud-rate generator
interface obi_uart_baudgen_if #(
  parameter int DIV_WIDTH = 16
);
  logic [DIV_WIDTH-1:0] divisor_i;
  logic [3:0]           frac_i;
  logic                 divisor_valid_i;
  logic                 oversample_edge_o;
  logic                 baud_rate_edge_o;
  logic                 double_rate_edge_o;

  modport master (
    output divisor_i, frac_i, divisor_valid_i,
    input  oversample_edge_o, baud_rate_edge_o, double_rate_edge_o
  );

  modport slave (
    input  divisor_i, frac_i, divisor_valid_i,
    output oversample_edge_o, baud_rate_edge_o, double_rate_edge_o
  );
endinterface

// File: rtl/obi_uart_baudgen.sv
// rtl/obi_uart_baudgen.sv - UART baud-rate generator: oversample, baud and double-rate strobes
// Optional fractional divisor: OBI_UART_BAUD_FRAC_EN
module obi_uart_baudgen #(
  parameter int DIV_WIDTH = 16,
  parameter int OVS       = 16
) (
  input logic               clk_i,
  input logic               rst_ni,
  obi_uart_baudgen_if.slave bus
);
  localparam int OvsW = $clog2(OVS);
  localparam logic [OvsW-1:0] OvsLast = OvsW'(OVS - 1);
  localparam logic [OvsW-1:0] OvsMid  = OvsW'(OVS / 2 - 1);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] pre_q;
  logic [OvsW-1:0]      ovs_q;
  logic                 ext_q;
  logic [DIV_WIDTH:0]   period_end;
  logic                 restart;
  logic                 enabled;
  logic                 tick;
  logic                 ovs_edge_q;
  logic                 baud_edge_q;
  logic                 dbl_edge_q;

  assign restart = bus.divisor_valid_i;
  assign enabled = (div_q != '0);

  // One extra bit so an extended period at the maximum divisor still compares correctly
  assign period_end = ext_q ? {1'b0, div_q} : ({1'b0, div_q} - 1'b1);
  assign tick       = enabled && ({1'b0, pre_q} == period_end);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q       <= '0;
      pre_q       <= '0;
      ovs_q       <= '0;
      ovs_edge_q  <= 1'b0;
      baud_edge_q <= 1'b0;
      dbl_edge_q  <= 1'b0;
    end else if (restart) begin
      div_q       <= bus.divisor_i;
      pre_q       <= '0;
      ovs_q       <= '0;
      ovs_edge_q  <= 1'b0;
      baud_edge_q <= 1'b0;
      dbl_edge_q  <= 1'b0;
    end else if (!enabled) begin
      pre_q       <= '0;
      ovs_q       <= '0;
      ovs_edge_q  <= 1'b0;
      baud_edge_q <= 1'b0;
      dbl_edge_q  <= 1'b0;
    end else begin
      ovs_edge_q  <= tick;
      baud_edge_q <= tick && (ovs_q == OvsLast);
      dbl_edge_q  <= tick && ((ovs_q == OvsLast) || (ovs_q == OvsMid));
      if (tick) begin
        pre_q <= '0;
        ovs_q <= ovs_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

`ifdef OBI_UART_BAUD_FRAC_EN
  logic [3:0] frac_q;
  logic [3:0] acc_q;
  logic [4:0] acc_sum;

  assign acc_sum = {1'b0, acc_q} + {1'b0, frac_q};

  // Carry out of the sixteenths accumulator stretches the following tick period by one cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frac_q <= '0;
      acc_q  <= '0;
      ext_q  <= 1'b0;
    end else if (restart) begin
      frac_q <= bus.frac_i;
      acc_q  <= '0;
      ext_q  <= 1'b0;
    end else if (!enabled) begin
      acc_q  <= '0;
      ext_q  <= 1'b0;
    end else if (tick) begin
      acc_q  <= acc_sum[3:0];
      ext_q  <= acc_sum[4];
    end
  end
`else
  assign ext_q = 1'b0;
`endif

  assign bus.oversample_edge_o  = ovs_edge_q;
  assign bus.baud_rate_edge_o   = baud_edge_q;
  assign bus.double_rate_edge_o = dbl_edge_q;
endmodule

// File: tb/tb_obi_uart_baudgen.sv
// tb/tb_obi_uart_baudgen.sv - self-checking bench for obi_uart_baudgen
`timescale 1ns/1ps
module tb_obi_uart_baudgen;
  localparam int DIV_WIDTH = 16;
  localparam int OVS       = 16;
`ifdef OBI_UART_BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;

  // Model state: when the last restart took effect and with which divisor
  int m_t0     = 0;
  int m_d      = 0;
  int m_f      = 0;
  bit m_active = 1'b0;

  int osc_t[$];
  int dbl_t[$];
  int baud_t[$];

  obi_uart_baudgen_if #(.DIV_WIDTH(DIV_WIDTH)) bus ();

  obi_uart_baudgen #(
    .DIV_WIDTH(DIV_WIDTH),
    .OVS      (OVS)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Tick k lands at k*D plus the number of carries out of the first k-1 accumulations
  function automatic int tick_index(input int m, input int d, input int f);
    if (m <= 0 || d <= 0) return 0;
    for (int k = 1; k * d <= m; k++)
      if (k * d + ((k - 1) * f) / 16 == m) return k;
    return 0;
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -100000;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active <= 1'b0;
    end else if (bus.divisor_valid_i) begin
      m_active <= (bus.divisor_i != '0);
      m_t0     <= cyc + 1;
      m_d      <= int'(bus.divisor_i);
      m_f      <= FRAC_ON ? int'(bus.frac_i) : 0;
    end
  end

  always @(negedge clk) begin
    int k;
    int eo;
    int ed;
    int eb;
    k  = (rst_n && m_active) ? tick_index(cyc - m_t0, m_d, m_f) : 0;
    eo = (k != 0) ? 1 : 0;
    ed = (k != 0 && (k % (OVS / 2)) == 0) ? 1 : 0;
    eb = (k != 0 && (k % OVS) == 0) ? 1 : 0;
    chk("oversample_edge", int'(bus.oversample_edge_o), eo);
    chk("double_rate_edge", int'(bus.double_rate_edge_o), ed);
    chk("baud_rate_edge", int'(bus.baud_rate_edge_o), eb);
    if (bus.oversample_edge_o)  osc_t.push_back(cyc);
    if (bus.double_rate_edge_o) dbl_t.push_back(cyc);
    if (bus.baud_rate_edge_o)   baud_t.push_back(cyc);
  end

  task automatic clear_logs();
    osc_t.delete();
    dbl_t.delete();
    baud_t.delete();
  endtask

  // Called at a falling edge; the divisor is latched on the next rising edge
  task automatic program_div(input int d, input int f);
    bus.divisor_i       = DIV_WIDTH'(d);
    bus.frac_i          = 4'(f);
    bus.divisor_valid_i = 1'b1;
    @(negedge clk);
    bus.divisor_valid_i = 1'b0;
    t0 = cyc;
    clear_logs();
  endtask

  initial begin
    int t1;
    bus.divisor_i       = '0;
    bus.frac_i          = '0;
    bus.divisor_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();

    repeat (200) @(negedge clk);
    chk("idle_no_strobes", osc_t.size() + dbl_t.size() + baud_t.size(), 0);

    program_div(3, 0);
    bus.divisor_i = DIV_WIDTH'(7);
    repeat (100) @(negedge clk);
    chk("d3_osc_first", qget(osc_t, 0) - t0, 3);
    chk("d3_osc_second", qget(osc_t, 1) - t0, 6);
    chk("d3_dbl_first", qget(dbl_t, 0) - t0, 24);
    chk("d3_dbl_second", qget(dbl_t, 1) - t0, 48);
    chk("d3_baud_first", qget(baud_t, 0) - t0, 48);
    chk("d3_baud_second", qget(baud_t, 1) - t0, 96);

    program_div(1, 0);
    repeat (40) @(negedge clk);
    chk("d1_osc_first", qget(osc_t, 0) - t0, 1);
    chk("d1_osc_back_to_back", qget(osc_t, 1) - qget(osc_t, 0), 1);
    chk("d1_baud_first", qget(baud_t, 0) - t0, 16);
    chk("d1_baud_spacing", qget(baud_t, 1) - qget(baud_t, 0), 16);
    chk("d1_dbl_spacing", qget(dbl_t, 1) - qget(dbl_t, 0), 8);

    program_div(2, 8);
    repeat (100) @(negedge clk);
    chk("frac_osc_period_a", qget(osc_t, 1) - qget(osc_t, 0), 2);
    chk("frac_osc_period_b", qget(osc_t, 2) - qget(osc_t, 1), FRAC_ON ? 3 : 2);
    chk("frac_baud_first", qget(baud_t, 0) - t0, FRAC_ON ? 39 : 32);
    chk("frac_baud_spacing", qget(baud_t, 1) - qget(baud_t, 0), FRAC_ON ? 40 : 32);

    program_div(4, 0);
    repeat (19) @(negedge clk);
    program_div(2, 0);
    t1 = t0;
    repeat (70) @(negedge clk);
    chk("restart_osc_first", qget(osc_t, 0) - t1, 2);
    chk("restart_baud_first", qget(baud_t, 0) - t1, 32);
    chk("restart_baud_second", qget(baud_t, 1) - t1, 64);
    chk("restart_no_stale_baud", baud_t.size(), 2);

    program_div(2, 0);
    repeat (20) @(negedge clk);
    program_div(0, 0);
    repeat (50) @(negedge clk);
    chk("div0_no_strobes", osc_t.size() + dbl_t.size() + baud_t.size(), 0);

    program_div(1, 0);
    repeat (10) @(negedge clk);
    chk("pre_reset_osc_high", int'(bus.oversample_edge_o), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_osc", int'(bus.oversample_edge_o), 0);
    chk("async_reset_dbl", int'(bus.double_rate_edge_o), 0);
    chk("async_reset_baud", int'(bus.baud_rate_edge_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    repeat (50) @(negedge clk);
    chk("post_reset_no_strobes", osc_t.size() + dbl_t.size() + baud_t.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
